// File: rtl/pll_reconfig_seq_if.sv
// pll_reconfig_seq_if
//   Bundles the command handshake from the UART command decoder and the
//   Avalon-MM master bus toward the PLL reconfig mgmt slave.
//   master : sequencer side (accepts commands, drives the Avalon requests)
//   slave  : environment side (issues commands, answers the Avalon requests)
interface pll_reconfig_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [17:0] cmd_n;
  logic [17:0] cmd_m;
  logic [17:0] cmd_c;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_n, cmd_m, cmd_c, avm_readdata, avm_waitrequest,
    output cmd_ready, busy, done, error,
           avm_address, avm_read, avm_write, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_n, cmd_m, cmd_c, avm_readdata, avm_waitrequest,
    input  cmd_ready, busy, done, error,
           avm_address, avm_read, avm_write, avm_writedata
  );
endinterface

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq
//   Turns one accepted (N, M, C) command into the PLL reconfig mgmt write
//   sequence (mode, N, M, C, start), then polls status until the reconfig
//   completes (done pulse) or the poll timeout expires (error pulse).
// Ports:
//   clk_clk     : sole clock, rising edge
//   reset_reset : asynchronous, active-high reset
//   pll_locked  : (only with PLL_RCFG_LOCK_WAIT_EN) async PLL lock indicator
//   bus         : command handshake + Avalon-MM master (master modport)
// Build option:
//   PLL_RCFG_LOCK_WAIT_EN : after status reports completion, also wait for
//                           the synchronised pll_locked before signalling done.
module pll_reconfig_seq #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int C_INDEX        = 0
) (
  input  logic clk_clk,
  input  logic reset_reset,
`ifdef PLL_RCFG_LOCK_WAIT_EN
  input  logic pll_locked,
`endif
  pll_reconfig_seq_if.master bus
);

  localparam int             CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TMO  = CW'(TIMEOUT_CYCLES);
  localparam logic [4:0]     CIDX = 5'(C_INDEX);

  // mgmt slave register map
  localparam logic [5:0] A_MODE   = 6'd0;
  localparam logic [5:0] A_STATUS = 6'd1;
  localparam logic [5:0] A_START  = 6'd2;
  localparam logic [5:0] A_N      = 6'd3;
  localparam logic [5:0] A_M      = 6'd4;
  localparam logic [5:0] A_C      = 6'd5;

  typedef enum logic [3:0] {
    IDLE,
    WR_MODE,
    WR_N,
    WR_M,
    WR_C,
    WR_START,
    RD_STATUS,
    POLL_GAP
`ifdef PLL_RCFG_LOCK_WAIT_EN
    , WAIT_LOCK
`endif
  } state_t;

  state_t        state, state_nx;
  logic [17:0]   n_q, m_q, c_q;
  logic [CW-1:0] cnt;
  logic          done_q, err_q, done_nx, err_nx;
  logic          xfer_ok;
  logic          accept;
  logic          unused_rdata;

  assign xfer_ok      = !bus.avm_waitrequest;
  assign accept       = bus.cmd_valid && (state == IDLE);
  assign unused_rdata = &{1'b0, bus.avm_readdata[31:1]};

`ifdef PLL_RCFG_LOCK_WAIT_EN
  logic [1:0] lock_sync;
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) lock_sync <= 2'b00;
    else             lock_sync <= {lock_sync[0], pll_locked};
  end
`endif

  // next state + terminal pulses
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE:     if (accept)  state_nx = WR_MODE;
      WR_MODE:  if (xfer_ok) state_nx = WR_N;
      WR_N:     if (xfer_ok) state_nx = WR_M;
      WR_M:     if (xfer_ok) state_nx = WR_C;
      WR_C:     if (xfer_ok) state_nx = WR_START;
      WR_START: if (xfer_ok) state_nx = RD_STATUS;
      RD_STATUS: begin
        if (xfer_ok) begin
          if (bus.avm_readdata[0]) begin
`ifdef PLL_RCFG_LOCK_WAIT_EN
            state_nx = WAIT_LOCK;
`else
            state_nx = IDLE;
            done_nx  = 1'b1;
`endif
          end else begin
            state_nx = POLL_GAP;
          end
        end
      end
      // timeout is only judged here, so an issued read always completes
      POLL_GAP: begin
        if (cnt >= TMO) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else begin
          state_nx = RD_STATUS;
        end
      end
`ifdef PLL_RCFG_LOCK_WAIT_EN
      WAIT_LOCK: begin
        if (lock_sync[1]) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (cnt >= TMO) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      n_q <= '0;
      m_q <= '0;
      c_q <= '0;
    end else if (accept) begin
      n_q <= bus.cmd_n;
      m_q <= bus.cmd_m;
      c_q <= bus.cmd_c;
    end
  end

  // poll timer: cleared as the start write completes, counts through the
  // whole polling phase and saturates at TMO
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cnt <= '0;
    end else if (state == WR_START && xfer_ok) begin
      cnt <= '0;
    end else if ((state == RD_STATUS || state == POLL_GAP
`ifdef PLL_RCFG_LOCK_WAIT_EN
                  || state == WAIT_LOCK
`endif
                 ) && cnt < TMO) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Avalon request decoded from state; latched command keeps it stable
  // across waitrequest
  always_comb begin
    bus.avm_write     = 1'b0;
    bus.avm_read      = 1'b0;
    bus.avm_address   = '0;
    bus.avm_writedata = '0;
    case (state)
      WR_MODE:   begin bus.avm_write = 1'b1; bus.avm_address = A_MODE;  bus.avm_writedata = 32'h1; end
      WR_N:      begin bus.avm_write = 1'b1; bus.avm_address = A_N;     bus.avm_writedata = {14'd0, n_q}; end
      WR_M:      begin bus.avm_write = 1'b1; bus.avm_address = A_M;     bus.avm_writedata = {14'd0, m_q}; end
      WR_C:      begin bus.avm_write = 1'b1; bus.avm_address = A_C;     bus.avm_writedata = {9'd0, CIDX, c_q}; end
      WR_START:  begin bus.avm_write = 1'b1; bus.avm_address = A_START; bus.avm_writedata = 32'h1; end
      RD_STATUS: begin bus.avm_read  = 1'b1; bus.avm_address = A_STATUS; end
      default:   ;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.error     = err_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
module tb_pll_reconfig_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_reconfig_seq_if if_a ();
  pll_reconfig_seq_if if_b ();

  pll_reconfig_seq dut_a (
    .clk_clk(clk), .reset_reset(rst),
`ifdef PLL_RCFG_LOCK_WAIT_EN
    .pll_locked(1'b1),
`endif
    .bus(if_a.master));

  pll_reconfig_seq #(.TIMEOUT_CYCLES(8), .C_INDEX(2)) dut_b (
    .clk_clk(clk), .reset_reset(rst),
`ifdef PLL_RCFG_LOCK_WAIT_EN
    .pll_locked(1'b1),
`endif
    .bus(if_b.master));

  // shared stimulus, sel picks which DUT is exercised/observed
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [17:0] cmd_n = '0, cmd_m = '0, cmd_c = '0;
  int          zeros_first = 0;
  int          rd_base = 0;
  int          stall_en = 0;
  int          stall_base = 0;
  int          wbase = 0;

  int          rd_cnt = 0, stall_cnt = 0, a4_ok = 0;
  logic [37:0] wlog[$];

  logic        o_ready, o_busy, o_done, o_err, o_rd, o_wr, waitreq;
  logic [5:0]  o_addr;
  logic [31:0] o_wd, rdata;

  assign o_ready = sel ? if_b.cmd_ready     : if_a.cmd_ready;
  assign o_busy  = sel ? if_b.busy          : if_a.busy;
  assign o_done  = sel ? if_b.done          : if_a.done;
  assign o_err   = sel ? if_b.error         : if_a.error;
  assign o_rd    = sel ? if_b.avm_read      : if_a.avm_read;
  assign o_wr    = sel ? if_b.avm_write     : if_a.avm_write;
  assign o_addr  = sel ? if_b.avm_address   : if_a.avm_address;
  assign o_wd    = sel ? if_b.avm_writedata : if_a.avm_writedata;

  // hold off the M write for exactly three cycles when stalling is enabled
  assign waitreq = (stall_en != 0) && o_wr && (o_addr == 6'd4) && ((stall_cnt - stall_base) < 3);
  // status reads return 0 for the first zeros_first reads of a command, then 1
  assign rdata   = {31'd0, ((rd_cnt - rd_base) >= zeros_first)};

  assign if_a.cmd_valid = cmd_valid & ~sel;
  assign if_b.cmd_valid = cmd_valid & sel;
  assign if_a.cmd_n = cmd_n;  assign if_b.cmd_n = cmd_n;
  assign if_a.cmd_m = cmd_m;  assign if_b.cmd_m = cmd_m;
  assign if_a.cmd_c = cmd_c;  assign if_b.cmd_c = cmd_c;
  assign if_a.avm_readdata = rdata;  assign if_b.avm_readdata = rdata;
  assign if_a.avm_waitrequest = waitreq;  assign if_b.avm_waitrequest = waitreq;

  always @(posedge clk) begin
    if (!rst) begin
      if (o_wr && !waitreq) wlog.push_back({o_addr, o_wd});
      if (o_rd && !waitreq) rd_cnt <= rd_cnt + 1;
      if (stall_en != 0 && o_wr && o_addr == 6'd4) stall_cnt <= stall_cnt + 1;
      if (o_wr && o_addr == 6'd4 && o_wd == 32'hC0C) a4_ok <= a4_ok + 1;
    end
  end

  int passed = 0, total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic [63:0] wr_mask, rd_mask;
  logic        busy_e, ready_e, both_e;
  int          lat, kind;

  // issue one command and follow it to done/error; cycle 1 is the cycle
  // right after the accepting edge
  task automatic run(input logic [17:0] n, m, c, input int zf, input int maxc);
    @(negedge clk);
    cmd_n = n; cmd_m = m; cmd_c = c;
    zeros_first = zf; rd_base = rd_cnt; wbase = wlog.size();
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; kind = 0; wr_mask = '0; rd_mask = '0;
    busy_e = 1'bx; ready_e = 1'bx; both_e = 1'bx;
    for (int k = 1; k <= maxc; k++) begin
      if (k < 64) begin wr_mask[k] = o_wr; rd_mask[k] = o_rd; end
      if (o_done || o_err) begin
        lat = k; kind = o_done ? 1 : 2;
        busy_e = o_busy; ready_e = o_ready; both_e = o_done & o_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int extra;
    #1;
    // reset state, both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_ready", o_ready, 1);
      check("rst_busy",  o_busy,  0);
      check("rst_done_err", {o_done, o_err}, 0);
      check("rst_rd_wr", {o_rd, o_wr}, 0);
      check("rst_addr_data", {o_addr, o_wd}, 0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // zero wait states, status 1 on first read
    run(18'h00202, 18'h00C0C, 18'h00404, 0, 60);
    check("t1_lat", lat, 7);
    check("t1_kind", kind, 1);
    check("t1_busy_ready", {busy_e, ready_e, both_e}, 3'b010);
    check("t1_wr_mask", wr_mask, 64'h3E);
    check("t1_rd_mask", rd_mask, 64'h40);
    check("t1_nwr", wlog.size() - wbase, 5);
    check("t1_w0", wlog[wbase+0], {6'd0, 32'h1});
    check("t1_w1", wlog[wbase+1], {6'd3, 32'h202});
    check("t1_w2", wlog[wbase+2], {6'd4, 32'hC0C});
    check("t1_w3", wlog[wbase+3], {6'd5, 32'h404});
    check("t1_w4", wlog[wbase+4], {6'd2, 32'h1});
    check("t1_nrd", rd_cnt - rd_base, 1);

    // three waitrequest cycles on the M write
    stall_en = 1; stall_base = stall_cnt;
    begin
      int a4_base;
      a4_base = a4_ok;
      run(18'h00202, 18'h00C0C, 18'h00404, 0, 60);
      check("t2_lat", lat, 10);
      check("t2_kind", kind, 1);
      check("t2_a4_stable", a4_ok - a4_base, 4);
      check("t2_nwr", wlog.size() - wbase, 5);
      check("t2_w2", wlog[wbase+2], {6'd4, 32'hC0C});
    end
    stall_en = 0;

    // status 0, 0, then 1
    run(18'h00011, 18'h00022, 18'h00033, 2, 60);
    check("t4_lat", lat, 11);
    check("t4_kind", kind, 1);
    check("t4_rd_mask", rd_mask, 64'h540);
    check("t4_nrd", rd_cnt - rd_base, 3);
    check("t4_w1", wlog[wbase+1], {6'd3, 32'h11});

    // reset while the N write is outstanding
    @(negedge clk);
    cmd_n = 18'h00202; cmd_m = 18'h00C0C; cmd_c = 18'h00404;
    zeros_first = 0; rd_base = rd_cnt;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t6_in_wr_n", {o_wr, o_addr}, {1'b1, 6'd3});
    #1 rst = 1'b1;
    #1;
    check("t6_async", {o_wr, o_busy, o_ready, o_addr}, {1'b0, 1'b0, 1'b1, 6'd0});
    @(negedge clk);
    rst = 1'b0;
    run(18'h00202, 18'h00C0C, 18'h00404, 0, 60);
    check("t6_lat", lat, 7);
    check("t6_nwr", wlog.size() - wbase, 5);
    check("t6_w0", wlog[wbase+0], {6'd0, 32'h1});

    // second instance: C_INDEX=2, TIMEOUT_CYCLES=8
    sel = 1'b1;
    @(negedge clk);
    run(18'h00202, 18'h00C0C, 18'h3FFFF, 0, 60);
    check("t3_lat", lat, 7);
    check("t3_wc", wlog[wbase+3], {6'd5, 32'h000BFFFF});

    run(18'h00202, 18'h00C0C, 18'h00404, 1000, 100);
    check("t5_kind", kind, 2);
    check("t5_lat", lat, 16);
    check("t5_busy_ready", {busy_e, ready_e, both_e}, 3'b010);
    check("t5_nrd", rd_cnt - rd_base, 5);
    check("t5_rd_mask", rd_mask, 64'h5540);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_err || o_done) extra++;
    end
    check("t5_no_more_pulses", extra, 0);
    check("t5_ready_end", o_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pll_reconfig_seq.md
# pll_reconfig_seq

Command-driven sequencer that masters the PLL reconfiguration management Avalon-MM slave. A single accepted command (N, M, C-counter settings) is turned into the full write sequence: polling mode, N, M, C, start. The block then polls status until reconfiguration completes or a timeout expires. It sits directly upstream of the PLL reconfig mgmt slave, fed by the UART command decoder.

## Interface

Parameters:
- TIMEOUT_CYCLES, 65535: maximum cycles spent polling status before aborting with error.
- C_INDEX, 0: C-counter index (0..17) placed in writedata[22:18] of the C-counter write.

Ports:
- clk_clk  in  1  sole clock; all logic rising-edge.
- reset_reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_n  in  18  raw N-counter register value.
- cmd_m  in  18  raw M-counter register value.
- cmd_c  in  18  raw C-counter register value.
- busy  out  1  high from acceptance until done/error.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on status-poll timeout.
- avm_address  out  6  mgmt slave word address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data, valid in the cycle avm_read && !avm_waitrequest.
- avm_waitrequest  in  1  slave stall.

## Operation

- Register map used: 0 mode, 1 status, 2 start, 3 N, 4 M, 5 C.
- States: IDLE, WR_MODE, WR_N, WR_M, WR_C, WR_START, RD_STATUS, POLL_GAP, [WAIT_LOCK], plus the terminal DONE/ERR action folded into the transition back to IDLE.
- Acceptance latches cmd_n/m/c into internal registers. Later input changes are ignored.
- Write data per state:
  - WR_MODE: addr 0, data 32'h1 (polling mode).
  - WR_N: addr 3, {14'd0, n}.
  - WR_M: addr 4, {14'd0, m}.
  - WR_C: addr 5, {9'd0, C_INDEX[4:0], c}.
  - WR_START: addr 2, data 32'h1.
- Avalon rules:
  - address, writedata, read and write are held stable while avm_waitrequest=1.
  - A transfer completes in the cycle where waitrequest=0.
  - read and write are never asserted together.
  - No request is driven in IDLE or POLL_GAP.
- RD_STATUS reads addr 1.
  - On completion with readdata[0]=1: return to IDLE with done pulse.
  - On completion with readdata[0]=0: go to POLL_GAP for exactly 1 cycle, then RD_STATUS again.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entering the first RD_STATUS.
  - Increments every cycle in RD_STATUS and POLL_GAP, saturating at TIMEOUT_CYCLES.
  - Evaluated only in POLL_GAP: if counter >= TIMEOUT_CYCLES, return to IDLE with error pulse instead of re-reading.
  - An in-flight read is never abandoned.
- done and error are never asserted together. busy falls in the same cycle as the pulse.

## Timing

- Reset values: cmd_ready=1, busy=0, done=0, error=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, state IDLE, counter 0.
- Outputs are driven from registers or state-decoded. They return to these values immediately on reset assertion.
- Reset mid-transfer drops the request asynchronously. The mgmt slave's own reset must be tied to the same reset.
- Zero-wait-state latency, acceptance at edge 0:
  - avm_write high in cycles 1–5.
  - avm_read in cycle 6.
  - If status=1, done=1 and cmd_ready=1 in cycle 7.
- Each waitrequest cycle extends the corresponding state by one cycle.
- A new command may be accepted in the cycle done/error is high.

## Configuration

- PLL_RCFG_LOCK_WAIT_EN defined:
  - Adds input pll_locked (1 bit, asynchronous, two-flop synchronised).
  - After status=1, enter WAIT_LOCK instead of IDLE.
  - WAIT_LOCK continues the same timeout counter.
  - Synchronised pll_locked=1 gives a done pulse. Timeout gives an error pulse.
  - Adds 3+ cycles to latency.
- Not defined: no pll_locked port and no WAIT_LOCK state. done issues directly after status=1.

## Test plan

- Zero wait states, cmd n=18'h00202, m=18'h00C0C, c=18'h00404, status=1 on first read.
  - Expected writes: (0,1), (3,0x202), (4,0xC0C), (5,0x404), (2,1).
  - Then one read of addr 1, done in cycle 7, busy low in cycle 7.
- waitrequest held 3 cycles on the WR_M write.
  - Address 4 and data stay stable for 4 cycles.
  - done arrives 3 cycles later than the zero-wait case.
- C_INDEX=2, c=18'h3FFFF → C write data 32'h000BFFFF.
- Status returns 0 twice, then 1 → read, gap, read, gap, read, done. No error.
- TIMEOUT_CYCLES=8, status always 0.
  - error pulses exactly once from POLL_GAP.
  - done never asserts; cmd_ready returns to 1.
- Reset asserted while avm_write=1 in WR_N.
  - avm_write=0, busy=0 and cmd_ready=1 without a clock edge.
  - A following command runs the full sequence from WR_MODE.
